// File: rtl/squash_sequencer.sv
// Squash sequencer: picks the oldest pending squash relative to the commit head,
// holds it across front-end stalls, and drops stale younger squashes after a redirect.
module squash_sequencer #(
    parameter int p_num_arb      = 4,
    parameter int p_seq_num_bits = 5,
    parameter int p_drain_cycles = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [p_num_arb-1:0]                  arb_val,
    input  logic [p_num_arb*p_seq_num_bits-1:0]   arb_seq_num,
    input  logic [p_num_arb*32-1:0]               arb_target,
    input  logic                                  fe_stall,
    input  logic                                  commit_val,
    input  logic [p_seq_num_bits-1:0]             commit_seq_num,
    output logic                                  gnt_val,
    output logic [p_seq_num_bits-1:0]             gnt_seq_num,
    output logic [31:0]                           gnt_target,
    output logic                                  busy
);
    localparam int B = p_seq_num_bits;

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_DRAIN} state_t;

    state_t         r_state, w_state_nxt;
    logic [B-1:0]   r_head, r_last_seq, r_p_seq, r_gnt_seq;
    logic [31:0]    r_p_tgt, r_gnt_tgt;
    logic           r_p_val, r_gnt_val;
    logic [3:0]     r_cnt;

    logic           w_c_val, w_m_val;
    logic [B-1:0]   w_c_seq, w_m_seq;
    logic [31:0]    w_c_tgt, w_m_tgt;

    // Distance from the head; B-bit truncation performs the modulo.
    function automatic logic [B-1:0] age(input logic [B-1:0] seq, input logic [B-1:0] head);
        return seq - head;
    endfunction

    // Oldest surviving requester; strict compare keeps the lowest index on ties.
    always_comb begin
        w_c_val = 1'b0;
        w_c_seq = '0;
        w_c_tgt = '0;
        for (int i = 0; i < p_num_arb; i++) begin
            if (arb_val[i]
                && !(r_state == S_DRAIN &&
                     age(arb_seq_num[i*B +: B], r_head) >= age(r_last_seq, r_head))
                && (!w_c_val || age(arb_seq_num[i*B +: B], r_head) < age(w_c_seq, r_head))) begin
                w_c_val = 1'b1;
                w_c_seq = arb_seq_num[i*B +: B];
                w_c_tgt = arb_target[i*32 +: 32];
            end
        end
    end

    always_comb begin
        w_m_val = r_p_val | w_c_val;
        w_m_seq = w_c_seq;
        w_m_tgt = w_c_tgt;
        if (r_p_val && (!w_c_val || age(r_p_seq, r_head) <= age(w_c_seq, r_head))) begin
            w_m_seq = r_p_seq;
            w_m_tgt = r_p_tgt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_m_val) begin
            w_state_nxt = fe_stall ? S_HOLD : S_DRAIN;
        end else if (r_state == S_DRAIN && r_cnt == 4'd1) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt_val  <= 1'b0;
            r_gnt_seq  <= '0;
            r_gnt_tgt  <= '0;
            r_head     <= '0;
            r_p_val    <= 1'b0;
            r_cnt      <= '0;
            r_last_seq <= '0;
        end else begin
            r_gnt_val <= 1'b0;
            if (commit_val) begin
                r_head <= commit_seq_num + 1'b1;
            end
            if (w_m_val) begin
                if (!fe_stall) begin
                    r_gnt_val  <= 1'b1;
                    r_gnt_seq  <= w_m_seq;
                    r_gnt_tgt  <= w_m_tgt;
                    r_p_val    <= 1'b0;
                    r_last_seq <= w_m_seq;
                    r_cnt      <= 4'(p_drain_cycles);
                end else begin
                    r_p_val <= 1'b1;
                end
            end else if (r_state == S_DRAIN && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Held squash payload; only meaningful while r_p_val is set.
    always_ff @(posedge clk) begin
        if (w_m_val && fe_stall) begin
            r_p_seq <= w_m_seq;
            r_p_tgt <= w_m_tgt;
        end
    end

    assign gnt_val     = r_gnt_val;
    assign gnt_seq_num = r_gnt_seq;
    assign gnt_target  = r_gnt_tgt;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_squash_sequencer.sv
// Bench for squash_sequencer: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_squash_sequencer;
    localparam int NA   = 4;
    localparam int B    = 5;
    localparam int D    = 3;
    localparam int MASK = (1 << B) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic [NA-1:0]       arb_val;
    logic [NA*B-1:0]     arb_seq_num;
    logic [NA*32-1:0]    arb_target;
    logic                fe_stall;
    logic                commit_val;
    logic [B-1:0]        commit_seq_num;
    logic                gnt_val;
    logic [B-1:0]        gnt_seq_num;
    logic [31:0]         gnt_target;
    logic                busy;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    squash_sequencer #(.p_num_arb(NA), .p_seq_num_bits(B), .p_drain_cycles(D)) dut (
        .clk(clk), .rst(rst), .arb_val(arb_val), .arb_seq_num(arb_seq_num),
        .arb_target(arb_target), .fe_stall(fe_stall), .commit_val(commit_val),
        .commit_seq_num(commit_seq_num), .gnt_val(gnt_val), .gnt_seq_num(gnt_seq_num),
        .gnt_target(gnt_target), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clr();
        arb_val        = '0;
        arb_seq_num    = '0;
        arb_target     = '0;
        fe_stall       = 1'b0;
        commit_val     = 1'b0;
        commit_seq_num = '0;
    endtask

    task automatic req(input int i, input int s, input logic [31:0] t);
        arb_val[i]             = 1'b1;
        arb_seq_num[i*B +: B]  = B'(s);
        arb_target[i*32 +: 32] = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: pending slot, drain window length, last granted seq.
    int          m_head, m_pv, m_ps, m_last, m_rem, m_gv, m_gs;
    logic [31:0] m_pt, m_gt;

    function automatic int age(input int x, input int h);
        return (x - h) & MASK;
    endfunction

    always @(posedge clk) begin
        int cv, cs, s, mv, ms;
        logic [31:0] ct, mt;
        bit drn;
        if (rst) begin
            m_head = 0; m_pv = 0; m_ps = 0; m_pt = 0; m_last = 0;
            m_rem = 0; m_gv = 0; m_gs = 0; m_gt = 0;
        end else begin
            drn = (m_pv == 0) && (m_rem > 0);
            cv = 0; cs = 0; ct = 0;
            for (int i = 0; i < NA; i++) begin
                s = int'(arb_seq_num[i*B +: B]);
                if (arb_val[i] && !(drn && age(s, m_head) >= age(m_last, m_head))
                    && (cv == 0 || age(s, m_head) < age(cs, m_head))) begin
                    cv = 1; cs = s; ct = arb_target[i*32 +: 32];
                end
            end
            if (m_pv != 0 && (cv == 0 || age(m_ps, m_head) <= age(cs, m_head))) begin
                mv = 1; ms = m_ps; mt = m_pt;
            end else begin
                mv = cv; ms = cs; mt = ct;
            end
            m_gv = 0;
            if (mv != 0) begin
                if (!fe_stall) begin
                    m_gv = 1; m_gs = ms; m_gt = mt; m_pv = 0; m_last = ms; m_rem = D;
                end else begin
                    m_pv = 1; m_ps = ms; m_pt = mt;
                end
            end else if (m_rem > 0) begin
                m_rem--;
            end
            if (commit_val) m_head = (int'(commit_seq_num) + 1) & MASK;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_gnt_val", 64'(gnt_val), 64'(m_gv));
            chk("model_gnt_seq", 64'(gnt_seq_num), 64'(m_gs));
            chk("model_gnt_target", 64'(gnt_target), 64'(m_gt));
            chk("model_busy", 64'(busy), 64'((m_pv != 0) || (m_rem > 0)));
        end
    end

    initial begin
        clr();
        rst = 1'b1;
        tick();
        tick();
        chk("reset_gnt_val", 64'(gnt_val), 0);
        chk("reset_busy", 64'(busy), 0);
        chk("reset_gnt_seq", 64'(gnt_seq_num), 0);
        chk("reset_gnt_target", 64'(gnt_target), 0);
        rst = 1'b0;
        cmp_en = 1'b1;
        repeat (10) begin
            tick();
            chk("idle_gnt_val", 64'(gnt_val), 0);
            chk("idle_busy", 64'(busy), 0);
        end

        // Single squash and drain window length
        req(2, 7, 32'h200);
        tick();
        chk("single_gnt_val", 64'(gnt_val), 1);
        chk("single_gnt_seq", 64'(gnt_seq_num), 7);
        chk("single_gnt_target", 64'(gnt_target), 64'h200);
        chk("single_busy_1", 64'(busy), 1);
        clr();
        tick();
        chk("single_pulse_end", 64'(gnt_val), 0);
        chk("single_busy_2", 64'(busy), 1);
        tick();
        chk("single_busy_3", 64'(busy), 1);
        tick();
        chk("single_busy_off", 64'(busy), 0);

        // Simultaneous requests
        req(0, 9, 32'h900);
        req(3, 4, 32'h400);
        tick();
        chk("simul_gnt_seq", 64'(gnt_seq_num), 4);
        chk("simul_gnt_target", 64'(gnt_target), 64'h400);
        clr();
        repeat (4) tick();
        chk("simul_busy_off", 64'(busy), 0);
        req(1, 5, 32'h510);
        req(2, 5, 32'h520);
        tick();
        chk("tie_gnt_val", 64'(gnt_val), 1);
        chk("tie_gnt_target", 64'(gnt_target), 64'h510);
        clr();
        repeat (4) tick();

        // Stall merge: 10, 6, 8 under stall -> single grant of 6
        fe_stall = 1'b1; req(0, 10, 32'hA00);
        tick();
        chk("stall_no_gnt_1", 64'(gnt_val), 0);
        chk("stall_busy", 64'(busy), 1);
        clr(); fe_stall = 1'b1; req(1, 6, 32'h600);
        tick();
        chk("stall_no_gnt_2", 64'(gnt_val), 0);
        clr(); fe_stall = 1'b1; req(2, 8, 32'h800);
        tick();
        chk("stall_no_gnt_3", 64'(gnt_val), 0);
        clr(); fe_stall = 1'b1;
        tick();
        chk("stall_no_gnt_4", 64'(gnt_val), 0);
        clr();
        tick();
        chk("merge_gnt_val", 64'(gnt_val), 1);
        chk("merge_gnt_seq", 64'(gnt_seq_num), 6);
        chk("merge_gnt_target", 64'(gnt_target), 64'h600);

        // Drain suppression, expiry, and older squash during drain
        req(0, 9, 32'h900);
        tick();
        chk("drain_drop_1", 64'(gnt_val), 0);
        tick();
        chk("drain_drop_2", 64'(gnt_val), 0);
        tick();
        chk("drain_drop_3", 64'(gnt_val), 0);
        chk("drain_expired_busy", 64'(busy), 0);
        tick();
        chk("after_drain_gnt_val", 64'(gnt_val), 1);
        chk("after_drain_gnt_seq", 64'(gnt_seq_num), 9);
        clr(); req(3, 3, 32'h300);
        tick();
        chk("older_in_drain_val", 64'(gnt_val), 1);
        chk("older_in_drain_seq", 64'(gnt_seq_num), 3);
        chk("older_in_drain_target", 64'(gnt_target), 64'h300);
        clr();
        repeat (5) tick();

        // Head wrap: head 30, seq 31 older than seq 1
        commit_val = 1'b1; commit_seq_num = 5'd29;
        tick();
        clr(); req(0, 1, 32'h100); req(1, 31, 32'h1F00);
        tick();
        chk("wrap_gnt_seq", 64'(gnt_seq_num), 31);
        chk("wrap_gnt_target", 64'(gnt_target), 64'h1F00);
        clr();
        repeat (5) tick();

        // Reset while holding a squash
        fe_stall = 1'b1; req(0, 12, 32'hC00);
        tick();
        chk("hold_busy", 64'(busy), 1);
        clr(); fe_stall = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; fe_stall = 1'b0;
        chk("rst_hold_busy", 64'(busy), 0);
        chk("rst_hold_gnt_seq", 64'(gnt_seq_num), 0);
        repeat (5) begin
            tick();
            chk("rst_hold_no_gnt", 64'(gnt_val), 0);
            chk("rst_hold_busy_after", 64'(busy), 0);
        end

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            clr();
            for (int i = 0; i < NA; i++) begin
                if ($urandom_range(0, 9) < 3) req(i, int'($urandom_range(0, MASK)), $urandom);
            end
            fe_stall       = ($urandom_range(0, 9) < 4);
            commit_val     = ($urandom_range(0, 9) < 3);
            commit_seq_num = B'($urandom_range(0, MASK));
            rst            = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        clr();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
